// File: rtl/toy_bus_mem_ack_buffer.sv
// Credit-gated ack buffer between a bus port and a fixed-latency memory node.
// Reads are admitted only while a FIFO slot is reserved, so node acks never need backpressure.
module toy_bus_mem_ack_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 256,
  parameter int SB_W   = 32,
  parameter int ID_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       up_req_vld,
  output logic                       up_req_rdy,
  input  logic [31:0]                up_req_addr,
  input  logic [DATA_W/8-1:0]        up_req_strb,
  input  logic [DATA_W-1:0]          up_req_data,
  input  logic                       up_req_opcode,
  input  logic [ID_W-1:0]            up_req_src_id,
  input  logic [ID_W-1:0]            up_req_tgt_id,
  input  logic [SB_W-1:0]            up_req_sideband,
  output logic                       dn_req_vld,
  input  logic                       dn_req_rdy,
  output logic [31:0]                dn_req_addr,
  output logic [DATA_W/8-1:0]        dn_req_strb,
  output logic [DATA_W-1:0]          dn_req_data,
  output logic                       dn_req_opcode,
  output logic [ID_W-1:0]            dn_req_src_id,
  output logic [ID_W-1:0]            dn_req_tgt_id,
  output logic [SB_W-1:0]            dn_req_sideband,
  input  logic                       dn_ack_vld,
  output logic                       dn_ack_rdy,
  input  logic                       dn_ack_opcode,
  input  logic [DATA_W-1:0]          dn_ack_data,
  input  logic [SB_W-1:0]            dn_ack_sideband,
  input  logic [ID_W-1:0]            dn_ack_src_id,
  input  logic [ID_W-1:0]            dn_ack_tgt_id,
  output logic                       up_ack_vld,
  input  logic                       up_ack_rdy,
  output logic                       up_ack_opcode,
  output logic [DATA_W-1:0]          up_ack_data,
  output logic [SB_W-1:0]            up_ack_sideband,
  output logic [ID_W-1:0]            up_ack_src_id,
  output logic [ID_W-1:0]            up_ack_tgt_id,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_overflow
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_W = 1 + DATA_W + SB_W + 2 * ID_W;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic admit;
  logic issue;
  logic pop;
  logic full;
  logic push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Writes bypass the credit check because the node never acks them.
  assign admit      = up_req_opcode | (outstanding < DEPTH_C);
  assign dn_req_vld = up_req_vld & admit;
  assign up_req_rdy = dn_req_rdy & admit;

  assign dn_req_addr     = up_req_addr;
  assign dn_req_strb     = up_req_strb;
  assign dn_req_data     = up_req_data;
  assign dn_req_opcode   = up_req_opcode;
  assign dn_req_src_id   = up_req_src_id;
  assign dn_req_tgt_id   = up_req_tgt_id;
  assign dn_req_sideband = up_req_sideband;

  assign dn_ack_rdy = 1'b1;

  assign issue   = dn_req_vld & dn_req_rdy & ~dn_req_opcode;
  assign pop     = up_ack_vld & up_ack_rdy;
  assign full    = (count == DEPTH_C);
  assign push_ok = dn_ack_vld & (~full | pop);

  assign up_ack_vld = (count != '0);
  assign {up_ack_opcode, up_ack_data, up_ack_sideband, up_ack_src_id, up_ack_tgt_id} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      outstanding  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop)     rd_ptr <= next_ptr(rd_ptr);

      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);

      // A push into a full FIFO without a same-cycle pop is dropped and flagged.
      if (dn_ack_vld && full && !pop) err_overflow <= 1'b1;

      if (issue && !pop && (outstanding != DEPTH_C))
        outstanding <= outstanding + CNT_W'(1);
      else if (!issue && pop && (outstanding != '0))
        outstanding <= outstanding - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {dn_ack_opcode, dn_ack_data, dn_ack_sideband, dn_ack_src_id, dn_ack_tgt_id};
  end

endmodule
